// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one 8-bit ALU between N requesters.
// A round-robin arbiter picks one pending request while idle. The winner's
// opcode and operands are captured, evaluated on the next cycle, and the
// result is held on a valid/ready port tagged with the owner's index.
module alu_rr_scheduler #(
  parameter int N     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [3*N-1:0]   op_flat,
  input  logic [8*N-1:0]   a_flat,
  input  logic [8*N-1:0]   b_flat,
  output logic [N-1:0]     ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [ID_W-1:0]  res_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [2:0]       op_q;
  logic [7:0]       a_q, b_q;
  logic [ID_W-1:0]  id_q;
  logic [7:0]       res_data_q;
  logic [ID_W-1:0]  res_id_q;
  logic [CNT_W-1:0] op_count_q;

  logic             grant_valid;
  logic [PTR_W-1:0] grant_idx;
  logic             capture;
  logic             handshake;
  logic [7:0]       alu_res;

  assign capture   = (state_q == IDLE) && grant_valid;
  assign handshake = (state_q == DONE) && res_ready;

  // Round-robin search starting at ptr_q; the lowest offset that requests wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[PTR_W'((int'(ptr_q) + i) % N)]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'((int'(ptr_q) + i) % N);
      end
    end
    // Pointer moves one past the winner, wrapping at N.
    ptr_d = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + PTR_W'(1);
    ack_d = capture ? (N'(1) << grant_idx) : '0;
  end

  // ALU on the captured operands; codes 101..111 yield zero.
  always_comb begin
    alu_res = 8'h00;
    case (op_q)
      3'b000:  alu_res = a_q + b_q;
      3'b001:  alu_res = {a_q[6:0], 1'b0};
      3'b010:  alu_res = a_q & b_q;
      3'b011:  alu_res = a_q ^ b_q;
      3'b100:  alu_res = (a_q > b_q) ? 8'h01 : 8'h00;
      default: alu_res = 8'h00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic: IDLE -> EXEC -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
  end

  // Datapath: capture on grant, register the result in EXEC, count handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      ack_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      op_count_q <= '0;
    end else begin
      ack_q <= ack_d;
      if (capture) begin
        op_q  <= op_flat[3*grant_idx +: 3];
        a_q   <= a_flat[8*grant_idx +: 8];
        b_q   <= b_flat[8*grant_idx +: 8];
        id_q  <= ID_W'(grant_idx);
        ptr_q <= ptr_d;
      end
      if (state_q == EXEC) begin
        res_data_q <= alu_res;
        res_id_q   <= id_q;
      end
      if (handshake) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign ack      = ack_q;
  assign res_data = res_data_q;
  assign res_id   = res_id_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed testbench for alu_rr_scheduler (N=4, CNT_W=4 so counter wrap is reachable).
module tb_alu_rr_scheduler;

  localparam int N     = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [3*N-1:0]   op_flat;
  logic [8*N-1:0]   a_flat;
  logic [8*N-1:0]   b_flat;
  logic [N-1:0]     ack;
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic [ID_W-1:0]  res_id;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int               vectors     = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_cnt;

  alu_rr_scheduler #(.N(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_flat   (op_flat),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .ack       (ack),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    op_flat[3*i +: 3] = op;
    a_flat[8*i +: 8]  = a;
    b_flat[8*i +: 8]  = b;
  endtask

  // One full grant/execute/handshake with res_ready=1 and req already driven.
  task automatic grant_cycle(input string tag, input int idx, input logic [7:0] exp_data, input bit drop);
    tick();
    check({tag, ".ack"},   32'(ack), 32'(1) << idx);
    check({tag, ".busy"},  32'(busy), 1);
    check({tag, ".vld0"},  32'(res_valid), 0);
    if (drop) req[idx] = 1'b0;
    tick();
    check({tag, ".ackoff"}, 32'(ack), 0);
    check({tag, ".vld1"},   32'(res_valid), 1);
    check({tag, ".data"},   32'(res_data), 32'(exp_data));
    check({tag, ".id"},     32'(res_id), idx);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    check({tag, ".vldhs"},  32'(res_valid), 0);
    check({tag, ".idle"},   32'(busy), 0);
    check({tag, ".cnt"},    32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    res_ready = 1'b0;
    op_flat   = '0;
    a_flat    = '0;
    b_flat    = '0;
    exp_cnt   = '0;
    #1;
    check("rst.ack",   32'(ack), 0);
    check("rst.vld",   32'(res_valid), 0);
    check("rst.data",  32'(res_data), 0);
    check("rst.id",    32'(res_id), 0);
    check("rst.busy",  32'(busy), 0);
    check("rst.cnt",   32'(op_count), 0);
    #10;
    rst = 1'b0;

    // Single add F0+20 with the consumer stalled for 5 cycles in DONE.
    set_slot(0, 3'b000, 8'hF0, 8'h20);
    req = 4'b0001;
    tick();
    check("t1.ack",  32'(ack), 32'h1);
    check("t1.busy", 32'(busy), 1);
    check("t1.vld0", 32'(res_valid), 0);
    req = 4'b0000;
    tick();
    check("t1.ackoff", 32'(ack), 0);
    check("t1.vld1",   32'(res_valid), 1);
    check("t1.data",   32'(res_data), 32'h10);
    check("t1.id",     32'(res_id), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3.vld",  32'(res_valid), 1);
      check("t3.data", 32'(res_data), 32'h10);
      check("t3.id",   32'(res_id), 0);
      check("t3.ack",  32'(ack), 0);
      check("t3.cnt",  32'(op_count), 0);
    end
    res_ready = 1'b1;
    tick();
    check("t3.vldhs", 32'(res_valid), 0);
    check("t3.cnt1",  32'(op_count), 1);
    check("t3.idle",  32'(busy), 0);

    // All four requesters held: round-robin order 0,1,2,3,0 from a fresh pointer.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    set_slot(0, 3'b000, 8'h10, 8'h01);
    set_slot(1, 3'b000, 8'h20, 8'h02);
    set_slot(2, 3'b000, 8'h30, 8'h03);
    set_slot(3, 3'b000, 8'h40, 8'h04);
    req = 4'b1111;
    grant_cycle("rr0", 0, 8'h11, 1'b0);
    grant_cycle("rr1", 1, 8'h22, 1'b0);
    grant_cycle("rr2", 2, 8'h33, 1'b0);
    grant_cycle("rr3", 3, 8'h44, 1'b0);
    grant_cycle("rr4", 0, 8'h11, 1'b0);
    req = 4'b0000;

    // Opcode sweep on requester 0, including carry drop and reserved codes.
    set_slot(0, 3'b000, 8'hFF, 8'h01); req[0] = 1'b1; grant_cycle("add_wrap", 0, 8'h00, 1'b1);
    set_slot(0, 3'b001, 8'h81, 8'h00); req[0] = 1'b1; grant_cycle("shl",      0, 8'h02, 1'b1);
    set_slot(0, 3'b010, 8'hA5, 8'h0F); req[0] = 1'b1; grant_cycle("and",      0, 8'h05, 1'b1);
    set_slot(0, 3'b100, 8'h05, 8'h05); req[0] = 1'b1; grant_cycle("cmp_eq",   0, 8'h00, 1'b1);
    set_slot(0, 3'b100, 8'h06, 8'h05); req[0] = 1'b1; grant_cycle("cmp_gt",   0, 8'h01, 1'b1);
    set_slot(0, 3'b100, 8'h00, 8'hFF); req[0] = 1'b1; grant_cycle("cmp_lt",   0, 8'h00, 1'b1);
    set_slot(0, 3'b111, 8'hFF, 8'h00); req[0] = 1'b1; grant_cycle("op111",    0, 8'h00, 1'b1);
    set_slot(0, 3'b101, 8'hFF, 8'h00); req[0] = 1'b1; grant_cycle("op101",    0, 8'h00, 1'b1);
    set_slot(0, 3'b011, 8'hFF, 8'h0F); req[0] = 1'b1; grant_cycle("xor",      0, 8'hF0, 1'b1);

    // Reset during EXEC with req=0110 held; pointer restarts at 0.
    set_slot(1, 3'b010, 8'h3C, 8'hF0);
    set_slot(2, 3'b011, 8'hAA, 8'h55);
    req = 4'b0110;
    tick();
    check("t5.ack", 32'(ack), 32'h2);
    #1;
    rst = 1'b1;
    #1;
    check("t5.ack0",  32'(ack), 0);
    check("t5.busy0", 32'(busy), 0);
    check("t5.vld0",  32'(res_valid), 0);
    check("t5.data0", 32'(res_data), 0);
    check("t5.id0",   32'(res_id), 0);
    check("t5.cnt0",  32'(op_count), 0);
    exp_cnt = '0;
    tick();
    check("t5.hold_busy", 32'(busy), 0);
    check("t5.hold_ack",  32'(ack), 0);
    rst = 1'b0;
    grant_cycle("t5.g1", 1, 8'h30, 1'b0);
    grant_cycle("t5.g2", 2, 8'hFF, 1'b0);
    req = 4'b0000;

    // Counter wrap: 16 handshakes return op_count to 0, the 17th gives 1.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    for (int k = 0; k < 17; k++) begin
      set_slot(0, 3'b000, 8'(k), 8'h01);
      req[0] = 1'b1;
      grant_cycle("wrap", 0, 8'(k + 1), 1'b1);
      if (k == 15) check("wrap16", 32'(op_count), 0);
    end
    check("wrap17", 32'(op_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
